sdf_stage_ctrl: RTL and testbench

SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

---
 rtl/sdf_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage: delay-line write,
// butterfly/bypass select, twiddle index and output framing for N = 2**LAYER samples.
//
// state | meaning
// IDLE  | no frame open; only a start sample opens one
// FILL  | first half of a frame enters the delay line; previous frame's differences leave
// BFLY  | second half; butterfly emits sums, differences go into the delay line
// DRAIN | no frame followed; flush the pending differences without new input
`timescale 1ns/1ps
module sdf_stage_ctrl #(
    parameter int LAYER = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_start,
    output logic             in_ready,
    output logic             dly_wea,
    output logic             bfly_sel,
    output logic [LAYER-2:0] tw_addr,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             err
);
    localparam int N = 1 << LAYER;
    localparam int H = N / 2;
    localparam logic [LAYER-1:0] CNT_ONE  = LAYER'(1);
    localparam logic [LAYER-1:0] CNT_HALF = LAYER'(H);
    localparam logic [LAYER-1:0] CNT_HM1  = LAYER'(H - 1);
    localparam logic [LAYER-1:0] CNT_MAX  = LAYER'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

    state_t           state_q;
    logic [LAYER-1:0] cnt_q;
    logic             pend_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_first_q;
    logic             out_last_q;
    logic             err_q;

    logic accept;
    logic in_frame;
    logic at_boundary;
    logic boundary_drop;
    logic idle_drop;
    logic start_step;
    logic restart;
    logic norm_step;
    logic drain_step;
    logic pend_step;

    assign accept        = in_valid & in_ready_q;
    assign in_frame      = (state_q == FILL) | (state_q == BFLY);
    // Index 0 of the next frame: the previous frame's differences are still queued.
    assign at_boundary   = (state_q == FILL) & (cnt_q == '0) & pend_q;
    assign boundary_drop = at_boundary & accept & ~in_start;
    assign idle_drop     = (state_q == IDLE) & accept & ~in_start;
    assign start_step    = (state_q == IDLE) & accept & in_start;
    assign restart       = in_frame & accept & in_start & (cnt_q != '0);
    assign norm_step     = in_frame & accept & ~restart & ~boundary_drop;
    assign drain_step    = (state_q == DRAIN);
    assign pend_step     = pend_q & (drain_step | (norm_step & (state_q == FILL)));

    assign dly_wea   = start_step | restart | norm_step | drain_step;
    assign bfly_sel  = norm_step & (state_q == BFLY);
    assign tw_addr   = pend_step ? cnt_q[LAYER-2:0] : '0;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            in_ready_q  <= (state_q != DRAIN);
            out_valid_q <= pend_step | bfly_sel;
            out_first_q <= bfly_sel & (cnt_q == CNT_HALF);
            out_last_q  <= pend_step & (cnt_q == CNT_HM1);
            err_q       <= idle_drop | boundary_drop | restart;

            case (state_q)
                IDLE: begin
                    if (start_step) begin
                        state_q <= FILL;
                        cnt_q   <= CNT_ONE;
                    end
                end
                FILL, BFLY: begin
                    if (restart) begin
                        state_q <= FILL;
                        cnt_q   <= CNT_ONE;
                        pend_q  <= 1'b0;
                    end else if (at_boundary && !(accept && in_start)) begin
                        state_q <= DRAIN;
                    end else if (norm_step) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (pend_step && cnt_q == CNT_HM1) begin
                            pend_q <= 1'b0;
                        end
                        if (state_q == FILL && cnt_q == CNT_HM1) begin
                            state_q <= BFLY;
                        end
                        if (state_q == BFLY && cnt_q == CNT_MAX) begin
                            state_q <= FILL;
                            pend_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == CNT_HM1) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: frame-level reference model compared every cycle,
// plus hand-computed timing and count expectations per directed scenario.
`timescale 1ns/1ps
module tb_sdf_stage_ctrl;
    localparam int LAYER = 4;
    localparam int N = 1 << LAYER;
    localparam int H = N / 2;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_start;
    logic in_ready;
    logic dly_wea;
    logic bfly_sel;
    logic [LAYER-2:0] tw_addr;
    logic out_valid;
    logic out_first;
    logic out_last;
    logic err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference model: frame position, differences still owed, drain cycles left
    bit m_in_frame;
    int m_pos;
    int m_diffs;
    int m_drain;
    bit m_ready;
    bit e_ov, e_of, e_ol, e_err;

    int ov_cnt, of_cnt, ol_cnt, err_cnt, dly_cnt, rdy_low_cnt, tw_sum;
    int first_cyc, last_cyc, err_cyc, rdy_low_first;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.LAYER(LAYER)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_start (in_start),
        .in_ready (in_ready),
        .dly_wea  (dly_wea),
        .bfly_sel (bfly_sel),
        .tw_addr  (tw_addr),
        .out_valid(out_valid),
        .out_first(out_first),
        .out_last (out_last),
        .err      (err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit acc, was_drain, c_dly, c_bfly, n_ov, n_of, n_ol, n_err;
        int c_tw;
        cyc++;
        if (!rst) begin
            m_in_frame = 0; m_pos = 0; m_diffs = 0; m_drain = 0; m_ready = 1;
            e_ov = 0; e_of = 0; e_ol = 0; e_err = 0;
            check("rst_in_ready", int'(in_ready), 1);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_last", int'(out_last), 0);
            check("rst_err", int'(err), 0);
            check("rst_dly_wea", int'(dly_wea), 0);
        end else begin
            check("in_ready", int'(in_ready), int'(m_ready));
            check("out_valid", int'(out_valid), int'(e_ov));
            check("out_first", int'(out_first), int'(e_of));
            check("out_last", int'(out_last), int'(e_ol));
            check("err", int'(err), int'(e_err));

            c_dly = 0; c_bfly = 0; c_tw = 0;
            n_ov = 0; n_of = 0; n_ol = 0; n_err = 0;
            acc = in_valid && m_ready;
            was_drain = (m_drain > 0);
            if (m_drain > 0) begin
                c_dly = 1; c_tw = H - m_diffs; n_ov = 1; n_ol = (m_diffs == 1);
                m_diffs--; m_drain--;
                if (m_drain == 0) m_in_frame = 0;
            end else if (!m_in_frame) begin
                if (acc && in_start) begin
                    c_dly = 1; m_in_frame = 1; m_pos = 1;
                end else if (acc) begin
                    n_err = 1;
                end
            end else if (m_pos == 0) begin
                if (acc && in_start) begin
                    c_dly = 1; c_tw = H - m_diffs; n_ov = 1; n_ol = (m_diffs == 1);
                    m_diffs--; m_pos = 1;
                end else begin
                    if (acc) n_err = 1;
                    m_drain = H;
                end
            end else if (acc && in_start) begin
                n_err = 1; c_dly = 1; m_pos = 1; m_diffs = 0;
            end else if (acc) begin
                c_dly = 1;
                if (m_pos >= H) begin
                    c_bfly = 1; n_ov = 1; n_of = (m_pos == H);
                end else if (m_diffs > 0) begin
                    c_tw = H - m_diffs; n_ov = 1; n_ol = (m_diffs == 1);
                    m_diffs--;
                end
                m_pos++;
                if (m_pos == N) begin
                    m_pos = 0; m_diffs = H;
                end
            end
            check("dly_wea", int'(dly_wea), int'(c_dly));
            check("bfly_sel", int'(bfly_sel), int'(c_bfly));
            check("tw_addr", int'(tw_addr), c_tw);
            m_ready = !was_drain;
            e_ov = n_ov; e_of = n_of; e_ol = n_ol; e_err = n_err;

            ov_cnt += int'(out_valid);
            of_cnt += int'(out_first);
            ol_cnt += int'(out_last);
            dly_cnt += int'(dly_wea);
            tw_sum += int'(tw_addr);
            if (out_first && first_cyc < 0) first_cyc = cyc;
            if (out_last) last_cyc = cyc;
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (!in_ready) begin
                if (rdy_low_cnt == 0) rdy_low_first = cyc;
                rdy_low_cnt++;
            end
        end
    end

    task automatic clr();
        ov_cnt = 0; of_cnt = 0; ol_cnt = 0; err_cnt = 0; dly_cnt = 0;
        rdy_low_cnt = 0; tw_sum = 0;
        first_cyc = -1; last_cyc = -1; err_cyc = -1; rdy_low_first = -1;
    endtask

    task automatic send(input int n, input bit start_first);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_start = (i == 0) && start_first;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : main
        int t0;
        int t1;
        rst = 1'b0; in_valid = 1'b0; in_start = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b1;
        idle(2);

        // single gapless frame followed by drain
        clr(); t0 = cyc + 1;
        send(16, 1); idle(14);
        check("s1_ov", ov_cnt, 16);
        check("s1_first_cyc", first_cyc, t0 + 9);
        check("s1_last_cyc", last_cyc, t0 + 25);
        check("s1_dly", dly_cnt, 24);
        check("s1_rdy_low_first", rdy_low_first, t0 + 18);
        check("s1_rdy_low_cnt", rdy_low_cnt, 8);
        check("s1_tw_sum", tw_sum, 28);

        // two back-to-back frames
        clr();
        send(16, 1); send(16, 1); idle(14);
        check("s2_ov", ov_cnt, 32);
        check("s2_first", of_cnt, 2);
        check("s2_last", ol_cnt, 2);
        check("s2_rdy_low_cnt", rdy_low_cnt, 8);
        check("s2_tw_sum", tw_sum, 56);
        check("s2_err", err_cnt, 0);

        // 3-cycle gap after sample 5
        clr(); t0 = cyc + 1;
        send(6, 1); idle(3); send(10, 0); idle(14);
        check("s3_ov", ov_cnt, 16);
        check("s3_first_cyc", first_cyc, t0 + 12);
        check("s3_last_cyc", last_cyc, t0 + 28);

        // start marker at sample 5 restarts the frame
        clr(); t0 = cyc + 1;
        send(5, 1); send(16, 1); idle(14);
        check("s4_err_cnt", err_cnt, 1);
        check("s4_err_cyc", err_cyc, t0 + 6);
        check("s4_ov", ov_cnt, 16);
        check("s4_first_cyc", first_cyc, t0 + 14);
        check("s4_last_cyc", last_cyc, t0 + 30);
        check("s4_last", ol_cnt, 1);

        // reset during third drain cycle
        clr(); t0 = cyc + 1;
        send(16, 1); idle(3);
        rst = 1'b0;
        #1;
        check("s5_in_ready", int'(in_ready), 1);
        check("s5_out_valid", int'(out_valid), 0);
        idle(2);
        rst = 1'b1;
        idle(12);
        check("s5_last", ol_cnt, 0);
        check("s5_ov", ov_cnt, 9);

        // stray sample in IDLE, then non-start sample at a frame boundary
        clr();
        send(1, 0); idle(2);
        t1 = cyc + 1;
        send(16, 1); send(1, 0); idle(14);
        check("s6_err_cnt", err_cnt, 2);
        check("s6_err_cyc", err_cyc, t1 + 17);
        check("s6_ov", ov_cnt, 16);
        check("s6_dly", dly_cnt, 24);
        check("s6_last_cyc", last_cyc, t1 + 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
